// File: rtl/register_file_param_if.sv
// Decode/write-back side bundle of the register file: one write port, two read ports.
// The master drives indices and write data; the register file (slave) returns read data.
interface register_file_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [WIDTH-1:0]  writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;

  modport master (
    output regWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised MIPS register file: 2**ADDR_W x WIDTH, two read ports, one write port,
// optional hardwired R0, optional write-to-read bypass and optional registered reads.
module register_file_param #(
  parameter int               WIDTH       = 32,
  parameter int               ADDR_W      = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               ZERO_REG    = 1,
  parameter int               BYPASS      = 1,
  parameter int               READ_REG    = 0
) (
  input logic                  clk,
  input logic                  reset,
  register_file_param_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             writeEn;

  // Writes to a hardwired R0 are dropped here so its storage stays at zero.
  assign writeEn = rf.regWrite && !((ZERO_REG != 0) && (rf.writeReg == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VALUE;
      end
    end else if (writeEn) begin
      regs[rf.writeReg] <= rf.writeData;
    end
  end

  // Per-port read selection; forwarding is suppressed while reset is held, since
  // the pending write will never land.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] idx;
    logic              isZero;
    logic              hit;
    logic [WIDTH-1:0]  sel;

    assign idx    = (p == 0) ? rf.readReg1 : rf.readReg2;
    assign isZero = (ZERO_REG != 0) && (idx == '0);
    assign hit    = (BYPASS != 0) && reset && rf.regWrite &&
                    (rf.writeReg == idx) && !isZero;
    assign sel    = isZero ? '0 : (hit ? rf.writeData : regs[idx]);
  end

  if (READ_REG != 0) begin : g_read_reg
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data1 <= '0;
        data2 <= '0;
      end else begin
        data1 <= g_port[0].sel;
        data2 <= g_port[1].sel;
      end
    end

    assign rf.readData1 = data1;
    assign rf.readData2 = data2;
  end else begin : g_read_comb
    assign rf.readData1 = g_port[0].sel;
    assign rf.readData2 = g_port[1].sel;
  end
endmodule
